// File: rtl/csoc_cmd_sequencer_pkg.sv
// csoc_seq_pkg: opcodes, reply codes and FSM states
// shared by the CSoC command sequencer files
package csoc_seq_pkg;

    localparam logic [7:0] OP_CTRL   = 8'h01;
    localparam logic [7:0] OP_STEP   = 8'h02;
    localparam logic [7:0] OP_WRITE  = 8'h03;
    localparam logic [7:0] OP_READ   = 8'h04;

    localparam logic [7:0] ACK_CTRL  = OP_CTRL;
    localparam logic [7:0] ACK_STEP  = OP_STEP;
    localparam logic [7:0] ACK_WRITE = OP_WRITE;
    localparam logic [7:0] ERR_OPC   = 8'hEE;
    localparam logic [7:0] ERR_TMO   = 8'hEF;

    typedef enum logic [2:0] {
        IDLE,
        GET_ARG,
        EXEC,
        CLK_HIGH,
        CLK_LOW,
        TX_SEND,
        TX_WAIT
    } state_t;

    function automatic logic has_arg(input logic [7:0] op);
        return (op == OP_CTRL) || (op == OP_STEP) || (op == OP_WRITE);
    endfunction

endpackage

// File: rtl/csoc_cmd_sequencer_if.sv
// UART byte port bundle between host-side uart_rx/uart_tx
// and the command sequencer
interface csoc_cmd_sequencer_if;

    logic [7:0] rx_data;
    logic       new_rx_data;
    logic [7:0] tx_data;
    logic       new_tx_data;
    logic       tx_busy;

    modport master (
        output rx_data, new_rx_data, tx_busy,
        input  tx_data, new_tx_data
    );

    modport slave (
        input  rx_data, new_rx_data, tx_busy,
        output tx_data, new_tx_data
    );

endinterface

// File: rtl/csoc_cmd_sequencer_pulse_gen.sv
// csoc_pulse_gen: emits a counted burst of csoc_clk pulses,
// each HALF_PERIOD cycles high then HALF_PERIOD cycles low
module csoc_pulse_gen #(
    parameter int HALF_PERIOD = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [8:0] count,
    output logic       csoc_clk,
    output logic       rise,
    output logic       done
);

    localparam int PW = $clog2(HALF_PERIOD);
    localparam logic [PW-1:0] PH_LAST = PW'(HALF_PERIOD - 1);

    logic [PW-1:0] phase;
    logic [8:0]    left;
    logic          run;
    logic          ph_end;

    assign ph_end = run && (phase == PH_LAST);
    assign done   = ph_end && !csoc_clk && (left == 9'd1);
    // rise marks the cycle whose closing edge takes csoc_clk 0->1
    assign rise   = start || (ph_end && !csoc_clk && (left != 9'd1));

    // phase/pulse counters; left counts pulses still owed incl. current
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csoc_clk <= 1'b0;
            phase    <= '0;
            left     <= '0;
            run      <= 1'b0;
        end else if (start) begin
            csoc_clk <= 1'b1;
            phase    <= '0;
            left     <= count;
            run      <= 1'b1;
        end else if (run) begin
            if (ph_end) begin
                phase <= '0;
                if (csoc_clk) begin
                    csoc_clk <= 1'b0;
                end else if (left == 9'd1) begin
                    run <= 1'b0;
                end else begin
                    csoc_clk <= 1'b1;
                    left     <= left - 9'd1;
                end
            end else begin
                phase <= phase + PW'(1);
            end
        end
    end

endmodule

// File: rtl/csoc_cmd_sequencer.sv
// csoc_cmd_sequencer: decodes host UART commands, drives CSoC
// test pins, steps csoc_clk and returns acks / captured data
module csoc_cmd_sequencer #(
    parameter int HALF_PERIOD = 25,
    parameter int ARG_TIMEOUT = 50000000
) (
    input  logic                        clk,
    input  logic                        rst,
    csoc_cmd_sequencer_if.slave         uart,
    output logic                        csoc_clk,
    output logic                        csoc_rstn,
    output logic                        csoc_test_se,
    output logic                        csoc_test_tm,
    output logic                        csoc_uart_read,
    output logic [7:0]                  csoc_data_o,
    input  logic                        csoc_uart_write,
    input  logic [7:0]                  csoc_data_i,
    output logic                        busy
);

    import csoc_seq_pkg::*;

    localparam int TW = $clog2(ARG_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(ARG_TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(ARG_TIMEOUT);

    state_t        state, state_nx;
    logic [7:0]    opcode, arg, reply, reply_val;
    logic [TW-1:0] tmo;
    logic          rd_reply, second;
    logic [7:0]    cap;
    logic          valid, lost, overrun;

    logic          op_we, arg_we, ctrl_we, wr_we, reply_we;
    logic          pg_start, tx_fire, next_byte, ovr_set;
    logic          pg_rise, pg_done, cap_en, flag_clr;
    logic [8:0]    pg_count;
    logic [7:0]    status, tx_byte;

    assign busy     = (state != IDLE);
    assign pg_count = (opcode == OP_WRITE) ? 9'd1 :
                      (arg == 8'd0)        ? 9'd256 : {1'b0, arg};
    assign cap_en   = pg_rise && csoc_uart_write;
    assign flag_clr = tx_fire && rd_reply && second;
    assign status   = {5'b0, lost, overrun, valid};
    assign tx_byte  = rd_reply ? (second ? cap : status) : reply;

    csoc_pulse_gen #(.HALF_PERIOD(HALF_PERIOD)) u_pulse (
        .clk      (clk),
        .rst      (rst),
        .start    (pg_start),
        .count    (pg_count),
        .csoc_clk (csoc_clk),
        .rise     (pg_rise),
        .done     (pg_done)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next state and per-state control strobes
    always_comb begin
        state_nx  = state;
        op_we     = 1'b0;
        arg_we    = 1'b0;
        ctrl_we   = 1'b0;
        wr_we     = 1'b0;
        reply_we  = 1'b0;
        reply_val = reply;
        pg_start  = 1'b0;
        tx_fire   = 1'b0;
        next_byte = 1'b0;
        ovr_set   = 1'b0;
        unique case (state)
            IDLE: begin
                if (uart.new_rx_data) begin
                    op_we = 1'b1;
                    if (uart.rx_data == OP_READ) begin
                        state_nx = TX_SEND;
                    end else if (has_arg(uart.rx_data)) begin
                        state_nx = GET_ARG;
                    end else begin
                        reply_we  = 1'b1;
                        reply_val = ERR_OPC;
                        state_nx  = TX_SEND;
                    end
                end
            end
            GET_ARG: begin
                if (uart.new_rx_data) begin
                    arg_we   = 1'b1;
                    ctrl_we  = (opcode == OP_CTRL);
                    state_nx = EXEC;
                end else if (tmo == TMO_LAST) begin
                    reply_we  = 1'b1;
                    reply_val = ERR_TMO;
                    state_nx  = TX_SEND;
                end
            end
            EXEC: begin
                ovr_set  = uart.new_rx_data;
                reply_we = 1'b1;
                if (opcode == OP_CTRL) begin
                    reply_val = ACK_CTRL;
                    state_nx  = TX_SEND;
                end else begin
                    reply_val = (opcode == OP_WRITE) ? ACK_WRITE : ACK_STEP;
                    wr_we     = (opcode == OP_WRITE);
                    pg_start  = 1'b1;
                    state_nx  = CLK_HIGH;
                end
            end
            CLK_HIGH: begin
                ovr_set = uart.new_rx_data;
                if (!csoc_clk) state_nx = CLK_LOW;
            end
            CLK_LOW: begin
                ovr_set = uart.new_rx_data;
                if (pg_done)      state_nx = TX_SEND;
                else if (pg_rise) state_nx = CLK_HIGH;
            end
            TX_SEND: begin
                ovr_set = uart.new_rx_data;
                if (!uart.tx_busy) begin
                    tx_fire  = 1'b1;
                    state_nx = TX_WAIT;
                end
            end
            TX_WAIT: begin
                ovr_set = uart.new_rx_data;
                // the strobe cycle itself is ignored: tx_busy lags it
                if (!uart.new_tx_data && !uart.tx_busy) begin
                    if (rd_reply && !second) begin
                        next_byte = 1'b1;
                        state_nx  = TX_SEND;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // opcode/argument/reply registers and argument timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opcode   <= '0;
            arg      <= '0;
            reply    <= '0;
            rd_reply <= 1'b0;
            second   <= 1'b0;
            tmo      <= '0;
        end else begin
            if (op_we) begin
                opcode   <= uart.rx_data;
                rd_reply <= (uart.rx_data == OP_READ);
                second   <= 1'b0;
            end
            if (next_byte) second <= 1'b1;
            if (arg_we)    arg    <= uart.rx_data;
            if (reply_we)  reply  <= reply_val;
            if (op_we)
                tmo <= '0;
            else if (state == GET_ARG && tmo != TMO_MAX)
                tmo <= tmo + TW'(1);
        end
    end

    // CSoC pin drivers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csoc_rstn      <= 1'b0;
            csoc_test_se   <= 1'b0;
            csoc_test_tm   <= 1'b0;
            csoc_uart_read <= 1'b0;
            csoc_data_o    <= '0;
        end else begin
            if (ctrl_we) begin
                csoc_rstn    <= uart.rx_data[0];
                csoc_test_se <= uart.rx_data[1];
                csoc_test_tm <= uart.rx_data[2];
            end
            if (wr_we) begin
                csoc_data_o    <= arg;
                csoc_uart_read <= 1'b1;
            end else if (pg_done) begin
                csoc_uart_read <= 1'b0;
            end
        end
    end

    // capture of CSoC output bytes and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap     <= '0;
            valid   <= 1'b0;
            lost    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (cap_en) cap <= csoc_data_i;
            if (cap_en)        valid <= 1'b1;
            else if (flag_clr) valid <= 1'b0;
            if (cap_en && valid) lost <= 1'b1;
            else if (flag_clr)   lost <= 1'b0;
            if (ovr_set)       overrun <= 1'b1;
            else if (flag_clr) overrun <= 1'b0;
        end
    end

    // registered transmit strobe and byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uart.tx_data     <= '0;
            uart.new_tx_data <= 1'b0;
        end else begin
            uart.new_tx_data <= tx_fire;
            if (tx_fire) uart.tx_data <= tx_byte;
        end
    end

endmodule

// File: tb/tb_csoc_cmd_sequencer.sv
// Directed bench for csoc_cmd_sequencer: a scoreboard queue of
// expected reply bytes checked by an independent tx monitor
module tb_csoc_cmd_sequencer;

    import csoc_seq_pkg::*;

    localparam int HP  = 4;
    localparam int TMO = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       csoc_clk, csoc_rstn, csoc_test_se, csoc_test_tm;
    logic       csoc_uart_read;
    logic [7:0] csoc_data_o;
    logic       csoc_uart_write;
    logic [7:0] csoc_data_i;
    logic       busy;

    int         checks = 0;
    int         errors = 0;
    int         strobes = 0;
    int         rises = 0;
    int         run = 0;
    logic       prev_clk = 1'b0;
    bit         run_chk = 1'b1;
    bit         hold = 1'b0;
    int         bcnt = 0;
    logic [7:0] exp_q[$];

    csoc_cmd_sequencer_if bus ();

    csoc_cmd_sequencer #(
        .HALF_PERIOD (HP),
        .ARG_TIMEOUT (TMO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .uart            (bus),
        .csoc_clk        (csoc_clk),
        .csoc_rstn       (csoc_rstn),
        .csoc_test_se    (csoc_test_se),
        .csoc_test_tm    (csoc_test_tm),
        .csoc_uart_read  (csoc_uart_read),
        .csoc_data_o     (csoc_data_o),
        .csoc_uart_write (csoc_uart_write),
        .csoc_data_i     (csoc_data_i),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name,
                       input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    // scoreboard monitor: every tx strobe pops one expected byte
    always @(negedge clk) begin
        if (!rst && bus.new_tx_data) begin
            strobes++;
            if (exp_q.size() == 0) begin
                chk(1'b0, "tx_unexpected", {24'd0, bus.tx_data}, 32'hFFFF);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                chk(bus.tx_data === e, "tx_byte", {24'd0, bus.tx_data}, {24'd0, e});
            end
        end
    end

    // simple transmitter model: busy for 3 cycles after each strobe
    always @(negedge clk) begin
        if (hold) begin
            bus.tx_busy = 1'b1;
        end else if (bus.new_tx_data) begin
            bcnt = 3;
            bus.tx_busy = 1'b1;
        end else if (bcnt > 0) begin
            bcnt--;
            bus.tx_busy = (bcnt != 0);
        end else begin
            bus.tx_busy = 1'b0;
        end
    end

    // csoc_clk pulse counter and phase length checker
    always @(negedge clk) begin
        if (csoc_clk !== prev_clk) begin
            if (run_chk && prev_clk)
                chk(run == HP, "high_run", run, HP);
            else if (run_chk && rises > 0)
                chk(run == HP, "low_run", run, HP);
            if (!prev_clk) rises++;
            run = 1;
        end else begin
            run++;
        end
        prev_clk = csoc_clk;
    end

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data     = b;
        bus.new_rx_data = 1'b1;
        @(negedge clk);
        bus.new_rx_data = 1'b0;
    endtask

    task automatic wait_idle(input int max, input string name);
        int n = 0;
        while (busy && n < max) begin
            @(negedge clk);
            n++;
        end
        chk(!busy, name, {31'd0, busy}, 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int s0;
        bus.rx_data     = 8'h00;
        bus.new_rx_data = 1'b0;
        bus.tx_busy     = 1'b0;
        csoc_uart_write = 1'b0;
        csoc_data_i     = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk(csoc_clk == 0, "rst_clk", csoc_clk, 0);
        chk(csoc_rstn == 0, "rst_rstn", csoc_rstn, 0);
        chk({csoc_test_se, csoc_test_tm, csoc_uart_read} == 3'b000,
            "rst_pins", {csoc_test_se, csoc_test_tm, csoc_uart_read}, 0);
        chk(csoc_data_o == 8'h00, "rst_data_o", csoc_data_o, 0);
        chk(busy == 0, "rst_busy", busy, 0);
        chk(bus.new_tx_data == 0, "rst_tx", bus.new_tx_data, 0);

        // READ after reset: empty status and capture
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        send_byte(OP_READ);
        wait_idle(100, "read0_idle");

        // reset in the middle of STEP 10 after 3 pulses
        run_chk = 1'b0;
        rises = 0;
        send_byte(OP_STEP);
        send_byte(8'd10);
        n = 0;
        while (rises < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(rises == 3, "mid_step_pulses", rises, 3);
        s0 = strobes;
        rst = 1'b1;
        #1;
        chk(csoc_clk == 0, "mid_rst_clk", csoc_clk, 0);
        chk(csoc_rstn == 0, "mid_rst_rstn", csoc_rstn, 0);
        chk(busy == 0, "mid_rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        chk(strobes == s0, "mid_rst_no_reply", strobes, s0);
        chk(busy == 0, "mid_rst_idle", busy, 0);
        run_chk = 1'b1;

        // CTRL 0x07: all three pins on, one cycle after arg strobe
        exp_q.push_back(ACK_CTRL);
        send_byte(OP_CTRL);
        chk({csoc_test_tm, csoc_test_se, csoc_rstn} == 3'b000, "ctrl_pre",
            {csoc_test_tm, csoc_test_se, csoc_rstn}, 0);
        send_byte(8'h07);
        chk({csoc_test_tm, csoc_test_se, csoc_rstn} == 3'b111, "ctrl_07",
            {csoc_test_tm, csoc_test_se, csoc_rstn}, 3'b111);
        wait_idle(100, "ctrl_idle");

        // CTRL 0xFA: upper bits ignored -> rstn=0 se=1 tm=0
        exp_q.push_back(ACK_CTRL);
        send_byte(OP_CTRL);
        send_byte(8'hFA);
        chk({csoc_test_tm, csoc_test_se, csoc_rstn} == 3'b010, "ctrl_fa",
            {csoc_test_tm, csoc_test_se, csoc_rstn}, 3'b010);
        wait_idle(100, "ctrl2_idle");

        // STEP 3
        rises = 0;
        exp_q.push_back(ACK_STEP);
        send_byte(OP_STEP);
        send_byte(8'd3);
        wait_idle(200, "step3_idle");
        chk(rises == 3, "step3_pulses", rises, 3);

        // WRITE 0xA5: one pulse with uart_read high
        rises = 0;
        exp_q.push_back(ACK_WRITE);
        send_byte(OP_WRITE);
        send_byte(8'hA5);
        n = 0;
        while (!csoc_clk && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(csoc_uart_read == 1, "write_read_hi", csoc_uart_read, 1);
        chk(csoc_data_o == 8'hA5, "write_data", csoc_data_o, 8'hA5);
        wait_idle(100, "write_idle");
        chk(csoc_uart_read == 0, "write_read_lo", csoc_uart_read, 0);
        chk(csoc_data_o == 8'hA5, "write_data_held", csoc_data_o, 8'hA5);
        chk(rises == 1, "write_pulses", rises, 1);

        // STEP 0 means 256 pulses
        rises = 0;
        exp_q.push_back(ACK_STEP);
        send_byte(OP_STEP);
        send_byte(8'd0);
        wait_idle(3000, "step256_idle");
        chk(rises == 256, "step256_pulses", rises, 256);

        // two captures at two rising edges: valid and lost
        rises = 0;
        csoc_uart_write = 1'b1;
        csoc_data_i     = 8'h3C;
        exp_q.push_back(ACK_STEP);
        send_byte(OP_STEP);
        send_byte(8'd2);
        wait_idle(200, "cap_step_idle");
        csoc_uart_write = 1'b0;
        csoc_data_i     = 8'h00;
        exp_q.push_back(8'h05);
        exp_q.push_back(8'h3C);
        send_byte(OP_READ);
        wait_idle(100, "read1_idle");
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h3C);
        send_byte(OP_READ);
        wait_idle(100, "read2_idle");

        // stray byte during EXEC is dropped and flags overrun
        rises = 0;
        exp_q.push_back(ACK_STEP);
        send_byte(OP_STEP);
        send_byte(8'd1);
        send_byte(8'h99);
        wait_idle(100, "ovr_idle");
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h3C);
        send_byte(OP_READ);
        wait_idle(100, "read3_idle");

        // unknown opcode while transmitter is held busy
        hold = 1'b1;
        @(negedge clk);
        s0 = strobes;
        exp_q.push_back(ERR_OPC);
        send_byte(8'h55);
        repeat (30) @(negedge clk);
        chk(strobes == s0, "hold_withheld", strobes, s0);
        chk(busy == 1, "hold_busy", busy, 1);
        hold = 1'b0;
        wait_idle(100, "hold_idle");
        chk(strobes == s0 + 1, "hold_released", strobes, s0 + 1);

        // argument timeout
        rises = 0;
        exp_q.push_back(ERR_TMO);
        send_byte(OP_STEP);
        wait_idle(200, "tmo_idle");
        chk(rises == 0, "tmo_no_pulse", rises, 0);

        repeat (5) @(negedge clk);
        chk(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
